// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code set 2 key tracker: decodes break/extended/pause prefixes, tracks modifiers,
// pulses key_valid with the plain make code. Define PS2_TYPEMATIC_EN to emit typematic repeats.
module ps2_key_tracker (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       shift,
  output logic       caps_lock
);

  typedef enum logic [2:0] {IDLE, BREAK, EXT, EXT_BREAK, PAUSE} state_t;

  state_t     state_q;
  logic       lshift_held_q, rshift_held_q, caps_held_q;
  logic [2:0] skip_cnt_q;
  logic [7:0] last_make_q;

  logic resync, emit_ok;
  assign resync = (rx_data == 8'h00) || (rx_data == 8'hFF);

`ifdef PS2_TYPEMATIC_EN
  assign emit_ok = 1'b1;
`else
  // A held key repeats its make code; only the first one of a press emits.
  assign emit_ok = (rx_data != last_make_q);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      lshift_held_q <= 1'b0;
      rshift_held_q <= 1'b0;
      caps_held_q   <= 1'b0;
      skip_cnt_q    <= 3'd0;
      last_make_q   <= 8'h00;
      key_code      <= 8'h00;
      key_valid     <= 1'b0;
      shift         <= 1'b0;
      caps_lock     <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (rx_valid) begin
        if (resync) begin
          state_q <= IDLE;
        end else begin
          case (state_q)
            IDLE: begin
              case (rx_data)
                8'hF0: state_q <= BREAK;
                8'hE0: state_q <= EXT;
                8'hE1: begin
                  state_q    <= PAUSE;
                  skip_cnt_q <= 3'd7;
                end
                8'hAA, 8'hFA, 8'hEE, 8'hFE: ;
                8'h12: begin
                  lshift_held_q <= 1'b1;
                  shift         <= 1'b1;
                end
                8'h59: begin
                  rshift_held_q <= 1'b1;
                  shift         <= 1'b1;
                end
                8'h58: begin
                  if (!caps_held_q) caps_lock <= ~caps_lock;
                  caps_held_q <= 1'b1;
                end
                default: begin
                  if (emit_ok) begin
                    key_code    <= rx_data;
                    key_valid   <= 1'b1;
                    last_make_q <= rx_data;
                  end
                end
              endcase
            end
            BREAK: begin
              if (rx_data != 8'hF0 && rx_data != 8'hE0) begin
                state_q <= IDLE;
                case (rx_data)
                  8'h12: begin
                    lshift_held_q <= 1'b0;
                    shift         <= rshift_held_q;
                  end
                  8'h59: begin
                    rshift_held_q <= 1'b0;
                    shift         <= lshift_held_q;
                  end
                  8'h58:   caps_held_q <= 1'b0;
                  default: ;
                endcase
                if (rx_data == last_make_q) last_make_q <= 8'h00;
              end
            end
            EXT:       state_q <= (rx_data == 8'hF0) ? EXT_BREAK : IDLE;
            EXT_BREAK: state_q <= IDLE;
            PAUSE: begin
              skip_cnt_q <= skip_cnt_q - 3'd1;
              if (skip_cnt_q <= 3'd1) state_q <= IDLE;
            end
            default:   state_q <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: reference model predicts the per-byte response,
// a monitor compares it one cycle after each accepted byte.
module tb_ps2_key_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] key_code;
  logic       key_valid;
  logic       shift;
  logic       caps_lock;

  ps2_key_tracker dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .key_code(key_code), .key_valid(key_valid), .shift(shift), .caps_lock(caps_lock)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         emit;
    logic [7:0] code;
    bit         sh;
    bit         cp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   pulses = 0;

  // Reference model: pending-prefix flags and a count of pause bytes still to swallow.
  int         m_pause;
  bit         m_brk, m_ext, m_extbrk;
  bit         m_ls, m_rs, m_caps_held, m_caps;
  logic [7:0] m_last, m_code;

  task automatic model_reset();
    m_pause = 0; m_brk = 0; m_ext = 0; m_extbrk = 0;
    m_ls = 0; m_rs = 0; m_caps_held = 0; m_caps = 0;
    m_last = 8'h00; m_code = 8'h00;
  endtask

  task automatic model_step(input logic [7:0] b, output exp_t e);
    bit emit = 0;
    if (b == 8'h00 || b == 8'hFF) begin
      m_pause = 0; m_brk = 0; m_ext = 0; m_extbrk = 0;
    end else if (m_pause > 0) begin
      m_pause--;
    end else if (m_extbrk) begin
      m_extbrk = 0;
    end else if (m_ext) begin
      m_ext = 0;
      m_extbrk = (b == 8'hF0);
    end else if (m_brk) begin
      if (b != 8'hF0 && b != 8'hE0) begin
        m_brk = 0;
        if (b == 8'h12) m_ls = 0;
        if (b == 8'h59) m_rs = 0;
        if (b == 8'h58) m_caps_held = 0;
        if (b == m_last) m_last = 8'h00;
      end
    end else begin
      if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hE1) m_pause = 7;
      else if (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE) ;
      else if (b == 8'h12) m_ls = 1;
      else if (b == 8'h59) m_rs = 1;
      else if (b == 8'h58) begin
        if (!m_caps_held) m_caps = !m_caps;
        m_caps_held = 1;
      end else begin
`ifdef PS2_TYPEMATIC_EN
        emit = 1;
`else
        emit = (b != m_last);
`endif
        if (emit) begin
          m_code = b;
          m_last = b;
        end
      end
    end
    e.emit = emit;
    e.code = m_code;
    e.sh   = m_ls | m_rs;
    e.cp   = m_caps;
  endtask

  task automatic send(input logic [7:0] b);
    exp_t e;
    model_step(b, e);
    exp_q.push_back(e);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send(s[i]);
    idle(1);
  endtask

  // Monitor: one cycle after an accepted byte, pop and compare; otherwise no pulse may appear.
  bit prev_v = 1'b0;
  always @(posedge clk) prev_v <= rst ? 1'b0 : rx_valid;

  always @(negedge clk) begin
    if (!rst) begin
      if (key_valid) pulses++;
      if (prev_v) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL scoreboard_underflow: output cycle with no expected record");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (key_valid !== e.emit || key_code !== e.code || shift !== e.sh || caps_lock !== e.cp) begin
            failures++;
            $display("FAIL byte_response: got vld=%b code=%h shift=%b caps=%b, want vld=%b code=%h shift=%b caps=%b",
                     key_valid, key_code, shift, caps_lock, e.emit, e.code, e.sh, e.cp);
          end
        end
      end else begin
        checks++;
        if (key_valid !== 1'b0) begin
          failures++;
          $display("FAIL idle_pulse: key_valid=%b with no byte, want 0", key_valid);
        end
      end
    end
  end

  task automatic check_pulses(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: pulses=%0d, want %0d", name, got, want);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] pool[12] = '{8'h1C, 8'h29, 8'h12, 8'h59, 8'h58, 8'hF0,
                           8'hE0, 8'hE1, 8'hAA, 8'h00, 8'hFF, 8'h32};

  initial begin
    int p0;
    model_reset();
    idle(2);
    @(negedge clk);
    checks++;
    if (key_code !== 8'h00 || key_valid !== 1'b0 || shift !== 1'b0 || caps_lock !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: code=%h vld=%b shift=%b caps=%b, want all 0",
               key_code, key_valid, shift, caps_lock);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    p0 = pulses; send_seq('{8'h1C, 8'hF0, 8'h1C});
    check_pulses("basic_press", pulses - p0, 1);

    p0 = pulses; send_seq('{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12});
    check_pulses("lshift_press", pulses - p0, 1);
    p0 = pulses; send_seq('{8'h59, 8'h12, 8'h1C, 8'hF0, 8'h59, 8'h2A, 8'hF0, 8'h12, 8'hF0, 8'h1C, 8'hF0, 8'h2A});
    check_pulses("both_shifts", pulses - p0, 2);

    p0 = pulses; send_seq('{8'h58, 8'h58, 8'h58, 8'hF0, 8'h58, 8'h58, 8'hF0, 8'h58});
    check_pulses("caps_toggle", pulses - p0, 0);

    p0 = pulses; send_seq('{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C, 8'hF0, 8'h1C});
`ifdef PS2_TYPEMATIC_EN
    check_pulses("typematic", pulses - p0, 4);
`else
    check_pulses("typematic", pulses - p0, 2);
`endif

    p0 = pulses;
    send_seq('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h12,
               8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'hAA});
    check_pulses("ext_pause_silent", pulses - p0, 0);
    p0 = pulses; send_seq('{8'h29, 8'hF0, 8'h29});
    check_pulses("after_pause", pulses - p0, 1);

    // Reset in the middle of a break prefix.
    send(8'h1C); send(8'hF0); idle(2);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (key_code !== 8'h00 || key_valid !== 1'b0 || shift !== 1'b0 || caps_lock !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: code=%h vld=%b shift=%b caps=%b, want all 0",
               key_code, key_valid, shift, caps_lock);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    idle(1);
    p0 = pulses; send_seq('{8'h1C});
    check_pulses("post_reset_make", pulses - p0, 1);
    send_seq('{8'hF0, 8'h1C});

    for (int i = 0; i < 2000; i++) begin
      logic [7:0] b;
      if ($urandom_range(0, 3) == 0) b = 8'($urandom);
      else b = pool[$urandom_range(0, 11)];
      send(b);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(3);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d records left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
